// File: rtl/vx_tcu_drl_exp_align_if.sv
// Handshake and data bundle for the DRL exponent-alignment stage.
// slave: the alignment stage itself; master: the upstream/downstream side.
interface vx_tcu_drl_exp_align_if #(
    parameter int N     = 2,
    parameter int EXP_W = 10,
    parameter int WA    = 28,
    parameter int TAG_W = 8
);
    localparam int TCK  = 2 * N;
    localparam int NT   = TCK + 1;
    localparam int SH_W = $clog2(WA + 1);

    logic                  valid_in;
    logic                  ready_in;
    logic [NT*EXP_W-1:0]   raw_exp_y;
    logic [TAG_W-1:0]      tag_in;
    logic                  valid_out;
    logic                  ready_out;
    logic [EXP_W-1:0]      max_exp;
    logic [NT*SH_W-1:0]    shift_amt;
    logic [NT-1:0]         zero_mask;
    logic                  all_zero;
    logic [TAG_W-1:0]      tag_out;

    modport master (
        output valid_in, raw_exp_y, tag_in, ready_out,
        input  ready_in, valid_out, max_exp, shift_amt, zero_mask, all_zero, tag_out
    );

    modport slave (
        input  valid_in, raw_exp_y, tag_in, ready_out,
        output ready_in, valid_out, max_exp, shift_amt, zero_mask, all_zero, tag_out
    );
endinterface

// File: rtl/vx_tcu_drl_exp_align.sv
// Exponent-alignment stage of the DRL FEDP datapath.
// S1 registers the raw exponents and their signed maximum; S2 registers the
// per-term right-shift amounts (saturated to WA), the zero mask and all_zero.
// Elastic 2-deep pipeline, valid/ready on both sides, no skid buffer.
module vx_tcu_drl_exp_align #(
    parameter int N     = 2,
    parameter int EXP_W = 10,
    parameter int WA    = 28,
    parameter int TAG_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    vx_tcu_drl_exp_align_if.slave   bus
);
    localparam int TCK    = 2 * N;
    localparam int NT     = TCK + 1;
    localparam int SH_W   = $clog2(WA + 1);
    localparam int LEAVES = 1 << $clog2(NT);

    localparam logic [EXP_W-1:0] EXP_NEG_INF = {1'b1, {(EXP_W-1){1'b0}}};
    localparam logic [SH_W-1:0]  SH_SAT      = SH_W'(WA);
    localparam logic [EXP_W:0]   DIFF_SAT    = (EXP_W+1)'(WA);

    // Balanced pairwise signed-max tree; unused leaves padded with NEG_INF so
    // they can never win.
    function automatic logic [EXP_W-1:0] max_tree(input logic [NT*EXP_W-1:0] raw);
        logic signed [EXP_W-1:0] node [1:2*LEAVES-1];
        for (int unsigned i = 0; i < NT; i++) begin
            node[LEAVES+i] = raw[i*EXP_W +: EXP_W];
        end
        for (int unsigned i = NT; i < LEAVES; i++) begin
            node[LEAVES+i] = EXP_NEG_INF;
        end
        for (int unsigned k = LEAVES - 1; k >= 1; k--) begin
            node[k] = (node[2*k] >= node[2*k+1]) ? node[2*k] : node[2*k+1];
        end
        return node[1];
    endfunction

    logic                  s1_valid_q;
    logic [NT*EXP_W-1:0]   s1_exp_q;
    logic [TAG_W-1:0]      s1_tag_q;
    logic [EXP_W-1:0]      s1_max_q;
    logic [EXP_W-1:0]      s1_max_d;

    logic                  s2_valid_q;
    logic [EXP_W-1:0]      s2_max_q,  s2_max_d;
    logic [NT*SH_W-1:0]    s2_sh_q,   s2_sh_d;
    logic [NT-1:0]         s2_zm_q,   s2_zm_d;
    logic                  s2_az_q,   s2_az_d;
    logic [TAG_W-1:0]      s2_tag_q;

    logic [EXP_W-1:0]      s2_e;
    logic [EXP_W:0]        s2_diff;

    logic                  s2_adv;
    logic                  rdy_in;
    logic                  s1_load;
    logic                  s2_load;

    // Handshake: S2 can take new data when empty or draining; S1 likewise.
    always_comb begin
        s2_adv  = ~s2_valid_q | bus.ready_out;
        rdy_in  = ~s1_valid_q | s2_adv;
        s1_load = bus.valid_in & rdy_in;
        s2_load = s1_valid_q & s2_adv;
    end

    // S1 next-state: maximum over all incoming terms.
    always_comb begin
        s1_max_d = max_tree(bus.raw_exp_y);
    end

    // S2 next-state: difference is taken one bit wider so it cannot wrap.
    always_comb begin
        s2_sh_d = '0;
        s2_zm_d = '0;
        s2_e    = '0;
        s2_diff = '0;
        for (int unsigned i = 0; i < NT; i++) begin
            s2_e       = s1_exp_q[i*EXP_W +: EXP_W];
            s2_diff    = {s1_max_q[EXP_W-1], s1_max_q} - {s2_e[EXP_W-1], s2_e};
            s2_zm_d[i] = (s2_e == EXP_NEG_INF);
            if (s2_zm_d[i] || (s2_diff >= DIFF_SAT)) begin
                s2_sh_d[i*SH_W +: SH_W] = SH_SAT;
            end else begin
                s2_sh_d[i*SH_W +: SH_W] = s2_diff[SH_W-1:0];
            end
        end
        s2_az_d  = &s2_zm_d;
        s2_max_d = s2_az_d ? EXP_NEG_INF : s1_max_q;
    end

    // Stage 1 registers: capture accepted step, valid tracks acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_exp_q   <= '0;
            s1_tag_q   <= '0;
            s1_max_q   <= EXP_NEG_INF;
        end else begin
            if (rdy_in) begin
                s1_valid_q <= bus.valid_in;
            end
            if (s1_load) begin
                s1_exp_q <= bus.raw_exp_y;
                s1_tag_q <= bus.tag_in;
                s1_max_q <= s1_max_d;
            end
        end
    end

    // Stage 2 registers: result held while the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_max_q   <= EXP_NEG_INF;
            s2_sh_q    <= '0;
            s2_zm_q    <= '0;
            s2_az_q    <= 1'b0;
            s2_tag_q   <= '0;
        end else begin
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
            end
            if (s2_load) begin
                s2_max_q <= s2_max_d;
                s2_sh_q  <= s2_sh_d;
                s2_zm_q  <= s2_zm_d;
                s2_az_q  <= s2_az_d;
                s2_tag_q <= s1_tag_q;
            end
        end
    end

    assign bus.ready_in  = rdy_in;
    assign bus.valid_out = s2_valid_q;
    assign bus.max_exp   = s2_max_q;
    assign bus.shift_amt = s2_sh_q;
    assign bus.zero_mask = s2_zm_q;
    assign bus.all_zero  = s2_az_q;
    assign bus.tag_out   = s2_tag_q;
endmodule
